// File: rtl/ssm_fp16_pkg.sv
// rtl/ssm_fp16_pkg.sv - FP16 constants, scheduler FIFO entry types and exp-argument clamp helper
package ssm_fp16_pkg;

  localparam int FP16_W = 16;
  localparam int TAG_W  = 4;

  localparam logic [15:0] FP16_ONE     = 16'h3C00;
  localparam logic [15:0] FP16_LN2     = 16'h398C;
  localparam logic [15:0] FP16_INV_LN2 = 16'h3DC5;
  localparam logic [15:0] FP16_NEG16   = 16'hCC00;
  localparam logic [15:0] FP16_HALF    = 16'h3800;

  typedef struct packed {
    logic [FP16_W-1:0] a;
    logic [TAG_W-1:0]  tag;
  } a_ent_t;

  typedef struct packed {
    logic [FP16_W-1:0] dt;
    logic [TAG_W-1:0]  tag;
  } dt_ent_t;

  typedef struct packed {
    logic [FP16_W-1:0] dt;
    logic [FP16_W-1:0] da;
    logic [TAG_W-1:0]  tag;
  } out_ent_t;

  // Negative values with |x| >= 16 (including -inf) saturate to -16; NaN payloads are above 15'h7C00.
  function automatic logic [15:0] clamp_exp_arg(input logic [15:0] x);
    if (x[15] && (x[14:0] >= 15'h4C00) && (x[14:0] <= 15'h7C00))
      return FP16_NEG16;
    return x;
  endfunction

endpackage

// File: rtl/fp16_mul.sv
// rtl/fp16_mul.sv - pipelined FP16 multiplier, round-to-nearest-even, subnormals flushed to zero
module fp16_mul #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        valid_o,
  output logic [15:0] p_o
);

  logic              sign;
  logic [4:0]        ea, eb;
  logic [9:0]        ma, mb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [21:0]       prod;
  logic signed [7:0] e;
  logic [9:0]        mant;
  logic              guard, sticky, carry;
  logic [9:0]        mant_r;
  logic [15:0]       p_comb;

  always_comb begin
    sign   = a_i[15] ^ b_i[15];
    ea     = a_i[14:10];
    eb     = b_i[14:10];
    ma     = a_i[9:0];
    mb     = b_i[9:0];
    a_nan  = (ea == 5'h1F) && (ma != 10'd0);
    b_nan  = (eb == 5'h1F) && (mb != 10'd0);
    a_inf  = (ea == 5'h1F) && (ma == 10'd0);
    b_inf  = (eb == 5'h1F) && (mb == 10'd0);
    a_zero = (ea == 5'd0);
    b_zero = (eb == 5'd0);
    prod   = {1'b1, ma} * {1'b1, mb};
    e      = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'sd15;
    if (prod[21]) begin
      mant   = prod[20:11];
      guard  = prod[10];
      sticky = |prod[9:0];
      e      = e + 8'sd1;
    end else begin
      mant   = prod[19:10];
      guard  = prod[9];
      sticky = |prod[8:0];
    end
    {carry, mant_r} = {1'b0, mant} + {10'd0, guard & (sticky | mant[0])};
    if (carry)
      e = e + 8'sd1;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      p_comb = 16'h7E00;
    else if (a_inf || b_inf)
      p_comb = {sign, 5'h1F, 10'd0};
    else if (a_zero || b_zero)
      p_comb = {sign, 15'd0};
    else if (e >= 8'sd31)
      p_comb = {sign, 5'h1F, 10'd0};
    else if (e <= 8'sd0)
      p_comb = {sign, 15'd0};
    else
      p_comb = {sign, e[4:0], mant_r};
  end

  logic [LAT-1:0] vld_q;
  logic [15:0]    p_q [LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= valid_i;
      for (int i = 1; i < LAT; i++)
        vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    p_q[0] <= p_comb;
    for (int i = 1; i < LAT; i++)
      p_q[i] <= p_q[i-1];
  end

  assign valid_o = vld_q[LAT-1];
  assign p_o     = p_q[LAT-1];

endmodule

// File: rtl/ssm_dt_da_scheduler_fifo.sv
// rtl/ssm_dt_da_scheduler_fifo.sv - first-word-fall-through synchronous FIFO (dtda_sync_fifo)
module dtda_sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push)
        wr_q <= wr_q + PW'(1);
      if (do_pop)
        rd_q <= rd_q + PW'(1);
      if (do_push && !do_pop)
        cnt_q <= cnt_q + (PW+1)'(1);
      else if (do_pop && !do_push)
        cnt_q <= cnt_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/ssm_dt_da_scheduler.sv
// rtl/ssm_dt_da_scheduler.sv - feeds dt_raw/dt*A through the shared softplus/exp unit, emits (dt, dA) pairs in order
// Build option SSM_DTDA_CLAMP_EN: saturate large negative exp arguments to -16.0.
module ssm_dt_da_scheduler
  import ssm_fp16_pkg::*;
#(
  parameter int DW      = 16,
  parameter int TW      = 4,
  parameter int DEPTH   = 16,
  parameter int LAT_MUL = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_dt_i,
  input  logic [DW-1:0] in_A_i,
  input  logic [TW-1:0] in_tag_i,
  output logic          sp_valid_o,
  output logic          sp_mode_o,
  output logic [DW-1:0] sp_x_o,
  input  logic [DW-1:0] sp_y_S_i,
  input  logic          sp_valid_S_i,
  input  logic [DW-1:0] sp_y_e_i,
  input  logic          sp_valid_e_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_dt_o,
  output logic [DW-1:0] out_dA_o,
  output logic [TW-1:0] out_tag_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] credit_q, credit_d;
  logic          alive_q;
  logic          sp_valid_q, sp_valid_d;
  logic          sp_mode_q, sp_mode_d;
  logic [DW-1:0] sp_x_q, sp_x_d;
  logic          err_q, err_d;

  logic          accept, sp_fire, e_fire, out_pop;
  logic          exp_req;
  logic [DW-1:0] mul_p, exp_arg;
  logic          a_full, a_empty, dt_full, dt_empty, out_full, out_empty;
  a_ent_t        a_wr, a_head;
  dt_ent_t       dt_wr, dt_head;
  out_ent_t      out_wr, out_head;

  // exp re-issue outranks new heads, so the unit never sees two requests in a cycle
  assign in_ready = alive_q & (credit_q != '0) & ~exp_req;
  assign accept   = in_valid & in_ready;
  assign sp_fire  = sp_valid_S_i & ~a_empty;
  assign e_fire   = sp_valid_e_i & ~dt_empty;
  assign out_pop  = out_valid & out_ready;

  assign a_wr   = '{a: in_A_i, tag: in_tag_i};
  assign dt_wr  = '{dt: sp_y_S_i, tag: a_head.tag};
  assign out_wr = '{dt: dt_head.dt, da: sp_y_e_i, tag: dt_head.tag};

  dtda_sync_fifo #(.WIDTH($bits(a_ent_t)), .DEPTH(DEPTH)) u_a_fifo (
    .clk(clk), .rstn(rstn), .push_i(accept), .wdata_i(a_wr), .pop_i(sp_fire),
    .rdata_o(a_head), .full_o(a_full), .empty_o(a_empty)
  );

  dtda_sync_fifo #(.WIDTH($bits(dt_ent_t)), .DEPTH(DEPTH)) u_dt_fifo (
    .clk(clk), .rstn(rstn), .push_i(sp_fire), .wdata_i(dt_wr), .pop_i(e_fire),
    .rdata_o(dt_head), .full_o(dt_full), .empty_o(dt_empty)
  );

  dtda_sync_fifo #(.WIDTH($bits(out_ent_t)), .DEPTH(DEPTH)) u_out_fifo (
    .clk(clk), .rstn(rstn), .push_i(e_fire), .wdata_i(out_wr), .pop_i(out_pop),
    .rdata_o(out_head), .full_o(out_full), .empty_o(out_empty)
  );

  fp16_mul #(.LAT(LAT_MUL)) u_mul (
    .clk(clk), .rstn(rstn), .valid_i(sp_fire), .a_i(sp_y_S_i), .b_i(a_head.a),
    .valid_o(exp_req), .p_o(mul_p)
  );

`ifdef SSM_DTDA_CLAMP_EN
  assign exp_arg = clamp_exp_arg(mul_p);
`else
  assign exp_arg = mul_p;
`endif

  always_comb begin
    credit_d   = credit_q;
    sp_valid_d = 1'b0;
    sp_mode_d  = sp_mode_q;
    sp_x_d     = sp_x_q;
    if (accept && !out_pop)
      credit_d = credit_q - CW'(1);
    else if (out_pop && !accept)
      credit_d = credit_q + CW'(1);
    if (exp_req) begin
      sp_valid_d = 1'b1;
      sp_mode_d  = 1'b0;
      sp_x_d     = exp_arg;
    end else if (accept) begin
      sp_valid_d = 1'b1;
      sp_mode_d  = 1'b1;
      sp_x_d     = in_dt_i;
    end
    err_d = err_q | (sp_valid_S_i & a_empty) | (sp_valid_e_i & dt_empty)
          | (accept & a_full) | (sp_fire & dt_full) | (e_fire & out_full);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credit_q   <= CW'(DEPTH);
      alive_q    <= 1'b0;
      sp_valid_q <= 1'b0;
      sp_mode_q  <= 1'b0;
      sp_x_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      credit_q   <= credit_d;
      alive_q    <= 1'b1;
      sp_valid_q <= sp_valid_d;
      sp_mode_q  <= sp_mode_d;
      sp_x_q     <= sp_x_d;
      err_q      <= err_d;
    end
  end

  assign sp_valid_o = sp_valid_q;
  assign sp_mode_o  = sp_mode_q;
  assign sp_x_o     = sp_x_q;

  // FIFO storage is not reset, so the output port is forced to zero while empty
  assign out_valid = ~out_empty;
  assign out_dt_o  = out_valid ? out_head.dt  : '0;
  assign out_dA_o  = out_valid ? out_head.da  : '0;
  assign out_tag_o = out_valid ? out_head.tag : '0;

`ifndef SYNTHESIS
  always @(posedge clk)
    if (rstn)
      assert (!err_q);
`endif

endmodule

// File: tb/tb_ssm_dt_da_scheduler.sv
// tb/tb_ssm_dt_da_scheduler.sv - scoreboard bench with a fixed-latency stand-in for the softplus/exp unit
module tb_ssm_dt_da_scheduler;

  localparam int LS = 3;
  localparam int LE = 4;

  typedef struct {
    logic [15:0] dt_raw;
    logic [15:0] a;
    logic [15:0] dt;
    logic [15:0] x;
    logic [15:0] da;
    logic [3:0]  tag;
  } tok_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready;
  logic [15:0] in_dt_i, in_A_i;
  logic [3:0]  in_tag_i;
  logic        sp_valid_o, sp_mode_o;
  logic [15:0] sp_x_o, sp_y_S_i, sp_y_e_i;
  logic        sp_valid_S_i, sp_valid_e_i;
  logic        out_valid, out_ready;
  logic [15:0] out_dt_o, out_dA_o;
  logic [3:0]  out_tag_o;

  always #5 clk = ~clk;

  ssm_dt_da_scheduler #(.DW(16), .TW(4), .DEPTH(16), .LAT_MUL(1)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dt_i(in_dt_i), .in_A_i(in_A_i), .in_tag_i(in_tag_i),
    .sp_valid_o(sp_valid_o), .sp_mode_o(sp_mode_o), .sp_x_o(sp_x_o),
    .sp_y_S_i(sp_y_S_i), .sp_valid_S_i(sp_valid_S_i),
    .sp_y_e_i(sp_y_e_i), .sp_valid_e_i(sp_valid_e_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dt_o(out_dt_o), .out_dA_o(out_dA_o), .out_tag_o(out_tag_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stand-in unit: known points return hand-computed results, everything else is identity / bit-invert
  function automatic logic [15:0] f_sp(input logic [15:0] x);
    case (x)
      16'h0000: return 16'h398C;
      16'h3C00: return 16'h3D41;
      16'h4B00: return 16'h4B00;
      default:  return x;
    endcase
  endfunction

  function automatic logic [15:0] f_exp(input logic [15:0] x);
    case (x)
      16'hB98C: return 16'h3800;
      16'hC141: return 16'h2CA1;
      default:  return ~x;
    endcase
  endfunction

  logic [LS-1:0] s_v;
  logic [15:0]   s_y [LS];
  logic [LE-1:0] e_v;
  logic [15:0]   e_y [LE];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_v <= '0;
      e_v <= '0;
    end else begin
      s_v[0] <= sp_valid_o & sp_mode_o;
      s_y[0] <= f_sp(sp_x_o);
      e_v[0] <= sp_valid_o & ~sp_mode_o;
      e_y[0] <= f_exp(sp_x_o);
      for (int i = 1; i < LS; i++) begin
        s_v[i] <= s_v[i-1];
        s_y[i] <= s_y[i-1];
      end
      for (int j = 1; j < LE; j++) begin
        e_v[j] <= e_v[j-1];
        e_y[j] <= e_y[j-1];
      end
    end
  end

  assign sp_valid_S_i = s_v[LS-1];
  assign sp_y_S_i     = s_y[LS-1];
  assign sp_valid_e_i = e_v[LE-1];
  assign sp_y_e_i     = e_y[LE-1];

  tok_t src[$];
  tok_t sb_exp[$];
  tok_t sb_out[$];
  int   n_out = 0;
  int   low_cycles = 0;

  logic        pend_v = 1'b0;
  logic [15:0] pend_x = '0;
  logic        prev_rdy = 1'b1;

  always @(negedge clk) begin
    tok_t t;
    if (!rstn) begin
      pend_v   = 1'b0;
      prev_rdy = 1'b1;
    end else begin
      if (pend_v) begin
        chk("sp_issue_softplus", {30'd0, sp_valid_o, sp_mode_o}, 32'd3);
        chk("sp_issue_x", sp_x_o, pend_x);
      end else if (sp_valid_o && sp_mode_o) begin
        chk("sp_spurious_softplus", 1, 0);
      end
      if (sp_valid_o && !sp_mode_o) begin
        chk("exp_issue_in_ready_low", prev_rdy, 0);
        if (sb_exp.size() == 0)
          chk("exp_issue_unexpected", 1, 0);
        else begin
          t = sb_exp.pop_front();
          chk("exp_issue_x", sp_x_o, t.x);
        end
      end
      if (in_valid && !in_ready)
        low_cycles++;
      pend_v   = in_valid & in_ready;
      pend_x   = in_dt_i;
      prev_rdy = in_ready;
      if (out_valid && out_ready) begin
        n_out++;
        if (sb_out.size() == 0)
          chk("out_unexpected", 1, 0);
        else begin
          t = sb_out.pop_front();
          chk("out_dt", out_dt_o, t.dt);
          chk("out_dA", out_dA_o, t.da);
          chk("out_tag", out_tag_o, t.tag);
        end
      end
    end
  end

  function automatic tok_t gen(input int n);
    tok_t t;
    t.dt_raw = 16'h4000 + 16'(n * 16);
    t.a      = 16'h3C00;
    t.dt     = t.dt_raw;
    t.x      = t.dt_raw;
    t.da     = ~t.dt_raw;
    t.tag    = 4'(n);
    return t;
  endfunction

  function automatic tok_t mk(input logic [15:0] dr, input logic [15:0] a, input logic [15:0] dt,
                              input logic [15:0] x, input logic [15:0] da, input logic [3:0] tag);
    tok_t t;
    t.dt_raw = dr; t.a = a; t.dt = dt; t.x = x; t.da = da; t.tag = tag;
    return t;
  endfunction

  task automatic send(input int n, input int budget, output int acc);
    tok_t t;
    int   cyc;
    acc = 0;
    cyc = 0;
    while (acc < n && cyc < budget && src.size() != 0) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_dt_i  = src[0].dt_raw;
      in_A_i   = src[0].a;
      in_tag_i = src[0].tag;
      @(negedge clk);
      if (in_ready) begin
        t = src.pop_front();
        sb_exp.push_back(t);
        sb_out.push_back(t);
        acc++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int c;
    c = 0;
    while ((sb_out.size() != 0 || sb_exp.size() != 0) && c < 400) begin
      @(posedge clk);
      c++;
    end
    chk(nm, sb_out.size() + sb_exp.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_in_ready"}, in_ready, 0);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_sp_valid"}, sp_valid_o, 0);
    chk({nm, "_sp_mode"}, sp_mode_o, 0);
    chk({nm, "_sp_x"}, sp_x_o, 0);
    chk({nm, "_out_data"}, {out_dt_o, out_dA_o} ^ {28'd0, out_tag_o}, 0);
  endtask

  initial begin
    int acc, n0;
    logic [15:0] cl_x, cl_da;
    rstn = 1'b0; in_valid = 1'b0; in_dt_i = '0; in_A_i = '0; in_tag_i = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("after_reset_in_ready", in_ready, 1);

    // single head: softplus(0)=ln2, ln2*-1, exp(-ln2)=0.5
    out_ready = 1'b1;
    n0 = n_out;
    src.push_back(mk(16'h0000, 16'hBC00, 16'h398C, 16'hB98C, 16'h3800, 4'd3));
    send(1, 20, acc);
    chk("t1_accepted", acc, 1);
    drain("t1_drain");
    chk("t1_one_output", n_out - n0, 1);

    // eight identical heads back-to-back, tag order preserved
    n0 = n_out;
    for (int i = 0; i < 8; i++)
      src.push_back(mk(16'h3C00, 16'hC000, 16'h3D41, 16'hC141, 16'h2CA1, 4'(i)));
    send(8, 100, acc);
    chk("t2_accepted", acc, 8);
    drain("t2_drain");
    chk("t2_outputs", n_out - n0, 8);

    // 14 * -14 = -196: clamped to -16 when the option is built in
`ifdef SSM_DTDA_CLAMP_EN
    cl_x = 16'hCC00; cl_da = 16'h33FF;
`else
    cl_x = 16'hDA20; cl_da = 16'h25DF;
`endif
    src.push_back(mk(16'h4B00, 16'hCB00, 16'h4B00, cl_x, cl_da, 4'd5));
    send(1, 20, acc);
    chk("t5_accepted", acc, 1);
    drain("t5_drain");

    // continuous input: exp re-issues must steal slots from new heads
    low_cycles = 0;
    n0 = n_out;
    for (int i = 100; i < 112; i++)
      src.push_back(gen(i));
    send(12, 200, acc);
    chk("t4_accepted", acc, 12);
    drain("t4_drain");
    chk("t4_outputs", n_out - n0, 12);
    chk("t4_in_ready_dropped", (low_cycles > 0) ? 1 : 0, 1);

    // reset with heads in flight
    out_ready = 1'b0;
    for (int i = 120; i < 125; i++)
      src.push_back(gen(i));
    send(5, 40, acc);
    chk("t6_accepted", acc, 5);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(negedge clk);
    chk_reset_outputs("t6_reset");
    sb_exp.delete();
    sb_out.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    out_ready = 1'b1;
    n0 = n_out;
    repeat (40) @(posedge clk);
    chk("t6_no_stale_outputs", n_out - n0, 0);

    // credit limit: 16 accepted with the consumer stalled, remaining 4 after release
    out_ready = 1'b0;
    n0 = n_out;
    for (int i = 130; i < 150; i++)
      src.push_back(gen(i));
    send(20, 60, acc);
    chk("t3_accepted_stalled", acc, 16);
    in_valid = 1'b1;
    @(negedge clk);
    chk("t3_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(4, 100, acc);
    chk("t3_accepted_after_release", acc, 4);
    drain("t3_drain");
    chk("t3_outputs", n_out - n0, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
